stream_framer: RTL
==================

STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 Parameter DW, default 128: stream data width in bits, multiple of 8, minimum 64.
REQ-002 Parameter MAX_META, default 4: maximum metadata beats per frame, range 1..15.
REQ-003 Parameter CNT_W, default 64: frame counter width, CNT_W <= DW.
REQ-004 Port clk  in  1  sole clock; all logic rising-edge.
REQ-005 Port resetn  in  1  asynchronous, active-low reset.
REQ-006 Port cfg_enable  in  1  start new frames while high.
REQ-007 Port cfg_data_beats  in  32  data beats per frame.
REQ-008 Port cfg_meta_beats  in  4  metadata beats per frame, 0..MAX_META.
REQ-009 Ports s_data_tdata/tvalid/tready  in/in/out  DW/1/1  payload AXI-Stream slave.
REQ-010 Ports s_meta_tdata/tvalid/tready  in/in/out  DW/1/1  metadata AXI-Stream slave.
REQ-011 Ports m_tdata/tvalid/tready/tlast/tkeep  out/out/in/out/out  DW/1/1/1/DW/8  framed AXI-Stream master.
REQ-012 Port frame_count  out  CNT_W  frames completed since reset.
REQ-013 Port fsm_state  out  2  current state encoding.

Function
REQ-014 FSM states SHALL be IDLE=0, DATA=1, META=2, TRAILER=3.
REQ-015 IDLE->DATA SHALL occur when cfg_enable=1; cfg_data_beats and cfg_meta_beats SHALL be latched at this transition and held for the frame.
REQ-016 Latched data beats of 0 SHALL be treated as 1; latched meta beats > MAX_META SHALL saturate to MAX_META.
REQ-017 DATA SHALL forward exactly the latched number of s_data beats, then go to META, or to TRAILER if latched meta beats = 0.
REQ-018 META SHALL forward exactly the latched number of s_meta beats, then go to TRAILER.
REQ-019 TRAILER SHALL emit one beat: m_tdata = frame_count zero-extended to DW, m_tlast=1; on acceptance return to IDLE.
REQ-020 m_tlast SHALL be 0 on all DATA and META beats; m_tkeep SHALL be all ones on every valid beat.
REQ-021 Output SHALL be a registered stage: a beat accepted from a slave appears on m_* the next cycle (latency 1).
REQ-022 s_data_tready SHALL be 1 only in DATA when the output register is empty or being drained (m_tready=1); s_meta_tready likewise only in META.
REQ-023 Beat counting SHALL advance only on slave handshake (tvalid & tready); stalls of any length on either side SHALL lose or duplicate no beat.
REQ-024 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tvalid SHALL remain stable.
REQ-025 frame_count SHALL increment by 1 on acceptance of the TRAILER beat and wrap from 2^CNT_W-1 to 0.
REQ-026 Deassertion of cfg_enable mid-frame SHALL NOT abort the frame; the FSM completes the frame and then stays in IDLE.
REQ-027 Config changes mid-frame SHALL have no effect until the next IDLE->DATA transition.
REQ-028 The unused slave SHALL see tready=0 in every state except its own.

Reset
REQ-029 On resetn=0, asynchronously: fsm_state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, frame_count=0, both slave treadys=0, beat counters=0.
REQ-030 Reset mid-frame SHALL discard the partial frame and the pending output beat; after release the first frame starts cleanly from IDLE.
REQ-031 Reset release SHALL take effect on the first rising clk edge after resetn=1; no output toggles before it.

Structure
REQ-032 Shared package stream_framer_pkg SHALL hold the state enumeration and the encoding constants for IDLE/DATA/META/TRAILER.
REQ-033 The output register SHALL be a sub-module axis_reg_slice (parameter DW, one-entry, tdata/tlast/tvalid/tready) reusable by other stream blocks.
REQ-034 Beat counter widths SHALL be 32 bits (data) and 4 bits (meta); no division in the datapath.

Verification
REQ-035 data_beats=4, meta_beats=1, m_tready=1, both slaves always valid -> 6 output beats: 4 data, 1 meta, trailer=0 with tlast; second frame trailer=1.
REQ-036 data_beats=3, meta_beats=2, m_tready toggling 1010..., random slave tvalid gaps -> output beat sequence identical to no-stall case, no data change while stalled.
REQ-037 meta_beats=0, data_beats=0 -> frame = 1 data beat + trailer; s_meta_tready never asserted.
REQ-038 cfg_enable dropped after 2nd of 8 data beats -> frame completes with 8 data, meta, trailer; FSM then holds IDLE, no further tready.
REQ-039 CNT_W=8, run 257 frames -> trailer values 0..255, then 0; frame_count=1 at end.
REQ-040 resetn pulsed low during META of frame 3 -> m_tvalid drops immediately, frame_count=0, next frame's trailer=0 and begins with data beat 1.

Source files
------------

// File: rtl/stream_framer_pkg.sv
// Shared definitions for the stream framer: state encoding and the rules
// that turn raw per-frame configuration into effective beat counts.
package stream_framer_pkg;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_DATA    = 2'd1;
    localparam logic [1:0] ENC_META    = 2'd2;
    localparam logic [1:0] ENC_TRAILER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_DATA    = ENC_DATA,
        ST_META    = ENC_META,
        ST_TRAILER = ENC_TRAILER
    } state_t;

    // A zero-length payload would leave the frame without a data phase.
    function automatic logic [31:0] eff_data_beats(input logic [31:0] cfg);
        return (cfg == 32'd0) ? 32'd1 : cfg;
    endfunction

    function automatic logic [3:0] eff_meta_beats(input logic [3:0] cfg,
                                                  input logic [3:0] max_meta);
        return (cfg > max_meta) ? max_meta : cfg;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXI-Stream stage; accepts a new beat whenever it is
// empty or its current beat is being drained in the same cycle.
module axis_reg_slice #(
    parameter int DW = 128
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic [DW-1:0] i_s_tdata,
    input  logic          i_s_tlast,
    input  logic          i_s_tvalid,
    output logic          o_s_tready,
    output logic [DW-1:0] o_m_tdata,
    output logic          o_m_tlast,
    output logic          o_m_tvalid,
    input  logic          i_m_tready
);

    logic [DW-1:0] r_data;
    logic          r_last;
    logic          r_valid;

    assign o_s_tready = !r_valid || i_m_tready;
    assign o_m_tdata  = r_data;
    assign o_m_tlast  = r_last;
    assign o_m_tvalid = r_valid;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_s_tready) begin
            r_valid <= i_s_tvalid;
            if (i_s_tvalid) begin
                r_data <= i_s_tdata;
                r_last <= i_s_tlast;
            end
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Builds frames of payload beats, optional metadata beats and a trailer
// carrying the running frame count, behind a one-entry output register.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int DW       = 128,
    parameter int MAX_META = 4,
    parameter int CNT_W    = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_enable,
    input  logic [31:0]      cfg_data_beats,
    input  logic [3:0]       cfg_meta_beats,
    input  logic [DW-1:0]    s_data_tdata,
    input  logic             s_data_tvalid,
    output logic             s_data_tready,
    input  logic [DW-1:0]    s_meta_tdata,
    input  logic             s_meta_tvalid,
    output logic             s_meta_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [DW/8-1:0]  m_tkeep,
    output logic [CNT_W-1:0] frame_count,
    output logic [1:0]       fsm_state
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_data_beats;
    logic [31:0]      r_data_cnt;
    logic [3:0]       r_meta_beats;
    logic [3:0]       r_meta_cnt;
    logic             r_trl_sent;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_slice_rdy;
    logic             w_in_valid;
    logic             w_in_last;
    logic [DW-1:0]    w_in_data;
    logic [DW-1:0]    w_trailer;
    logic             w_data_hs;
    logic             w_meta_hs;
    logic             w_data_done;
    logic             w_meta_done;
    logic             w_trl_push;
    logic             w_trl_acc;

    assign w_data_hs   = s_data_tvalid && s_data_tready;
    assign w_meta_hs   = s_meta_tvalid && s_meta_tready;
    assign w_data_done = w_data_hs && (r_data_cnt == r_data_beats - 32'd1);
    assign w_meta_done = w_meta_hs && (r_meta_cnt == r_meta_beats - 4'd1);
    assign w_trl_push  = (r_state == ST_TRAILER) && !r_trl_sent && w_slice_rdy;
    // Once the trailer is pushed it is the only beat left in the slice.
    assign w_trl_acc   = (r_state == ST_TRAILER) && r_trl_sent && m_tvalid && m_tready;

    assign m_tkeep     = '1;
    assign frame_count = r_frame_cnt;
    assign fsm_state   = r_state;

    always_comb begin
        w_trailer = '0;
        w_trailer[CNT_W-1:0] = r_frame_cnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (cfg_enable) w_next = ST_DATA;
            ST_DATA:    if (w_data_done) w_next = (r_meta_beats == 4'd0) ? ST_TRAILER : ST_META;
            ST_META:    if (w_meta_done) w_next = ST_TRAILER;
            ST_TRAILER: if (w_trl_acc) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_data_tready = 1'b0;
        s_meta_tready = 1'b0;
        w_in_valid    = 1'b0;
        w_in_last     = 1'b0;
        w_in_data     = '0;
        case (r_state)
            ST_DATA: begin
                s_data_tready = w_slice_rdy;
                w_in_valid    = s_data_tvalid;
                w_in_data     = s_data_tdata;
            end
            ST_META: begin
                s_meta_tready = w_slice_rdy;
                w_in_valid    = s_meta_tvalid;
                w_in_data     = s_meta_tdata;
            end
            ST_TRAILER: begin
                w_in_valid = !r_trl_sent;
                w_in_last  = 1'b1;
                w_in_data  = w_trailer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_beats <= '0;
            r_data_cnt   <= '0;
            r_meta_beats <= '0;
            r_meta_cnt   <= '0;
            r_trl_sent   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            if (r_state == ST_IDLE && cfg_enable) begin
                r_data_beats <= eff_data_beats(cfg_data_beats);
                r_meta_beats <= eff_meta_beats(cfg_meta_beats, 4'(MAX_META));
                r_data_cnt   <= '0;
                r_meta_cnt   <= '0;
            end
            if (w_data_hs) r_data_cnt <= w_data_done ? 32'd0 : r_data_cnt + 32'd1;
            if (w_meta_hs) r_meta_cnt <= w_meta_done ? 4'd0 : r_meta_cnt + 4'd1;
            if (w_trl_push) r_trl_sent <= 1'b1;
            if (w_trl_acc) begin
                r_trl_sent  <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    axis_reg_slice #(.DW(DW)) u_out_slice (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_s_tdata  (w_in_data),
        .i_s_tlast  (w_in_last),
        .i_s_tvalid (w_in_valid),
        .o_s_tready (w_slice_rdy),
        .o_m_tdata  (m_tdata),
        .o_m_tlast  (m_tlast),
        .o_m_tvalid (m_tvalid),
        .i_m_tready (m_tready)
    );

endmodule
